// File: rtl/mbist_fail_log_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mbist_fail_log_pkg
// Description : Shared MBIST constants. Holds the fail-log FSM state encoding
//               and the default log geometry. Used by mbist_fail_log and
//               alongside mbist_top.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mbist_fail_log_pkg;

    localparam int c_ADDR_DEFAULT  = 6;
    localparam int c_DEPTH_DEFAULT = 8;
    localparam int c_CNT_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        CAPTURE = 2'b01,
        DONE    = 2'b10
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mbist_fail_log_if.sv
`default_nettype none
// ============================================================================
// Module      : mbist_fail_log_if
// Description : Bundle of BIST compare inputs and fail-log readout signals.
// Ports       : slave  - the fail logger (consumes BIST traffic, drives log)
//               master - the BIST controller / readout agent
//               mode, rd_stb, addr_bist, exp_data, mem_d_out, bist_done,
//               log_pop (master -> slave); log_valid, log_addr, log_exp,
//               log_cnt, fail_cnt, overflow, diag_done (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface mbist_fail_log_if
    import mbist_fail_log_pkg::*;
#(
    parameter int ADDR  = c_ADDR_DEFAULT,
    parameter int DEPTH = c_DEPTH_DEFAULT,
    parameter int CNT_W = c_CNT_W_DEFAULT
);
    logic                     mode;
    logic                     rd_stb;
    logic [ADDR-1:0]          addr_bist;
    logic                     exp_data;
    logic                     mem_d_out;
    logic                     bist_done;
    logic                     log_pop;

    logic                     log_valid;
    logic [ADDR-1:0]          log_addr;
    logic                     log_exp;
    logic [$clog2(DEPTH):0]   log_cnt;
    logic [CNT_W-1:0]         fail_cnt;
    logic                     overflow;
    logic                     diag_done;

    modport slave (
        input  mode, rd_stb, addr_bist, exp_data, mem_d_out, bist_done, log_pop,
        output log_valid, log_addr, log_exp, log_cnt, fail_cnt, overflow, diag_done
    );

    modport master (
        output mode, rd_stb, addr_bist, exp_data, mem_d_out, bist_done, log_pop,
        input  log_valid, log_addr, log_exp, log_cnt, fail_cnt, overflow, diag_done
    );

endinterface
`default_nettype wire

// File: rtl/mbist_log_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mbist_log_fifo
// Description : Synchronous-write FIFO holding failure-log entries.
//               DEPTH must be a power of two (>= 2) so pointers wrap freely.
// Ports       : clk, rst_n  - clock, async active-low reset
//               i_clr       - synchronous flush (pointers and count to 0)
//               i_push/i_wdata - write request/data (ignored when full)
//               i_pop       - read request (ignored when empty)
//               o_rdata     - head entry; o_count, o_full, o_empty - status
// Revision    : 1.0 - initial release
// ============================================================================
module mbist_log_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_clr,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_rdata,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_wr_en;
    logic             w_rd_en;

    assign w_wr_en = i_push && !o_full;
    assign w_rd_en = i_pop && !o_empty;

    // Storage is not reset; validity is tracked entirely by r_count.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/mbist_fail_log.sv
`default_nettype none
// ============================================================================
// Module      : mbist_fail_log
// Description : MBIST failure logger. Compares RAM read data against the
//               BIST expected value (read latency 1), counts mismatches,
//               logs distinct failing addresses into a FIFO and freezes the
//               log for readout once BIST completes.
// Ports       : clk    - system clock
//               rst_n  - async active-low reset
//               bus_if - mbist_fail_log_if.slave (BIST inputs, log readout)
// Revision    : 1.0 - initial release
// ============================================================================
module mbist_fail_log
    import mbist_fail_log_pkg::*;
#(
    parameter int ADDR  = c_ADDR_DEFAULT,
    parameter int DEPTH = c_DEPTH_DEFAULT,
    parameter int CNT_W = c_CNT_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    mbist_fail_log_if.slave bus_if
);
    localparam int LCW = $clog2(DEPTH) + 1;

    state_t           r_state;
    state_t           w_next;
    logic             w_enter;

    logic             r_stb_d;
    logic [ADDR-1:0]  r_addr_d;
    logic             r_exp_d;

    logic [CNT_W-1:0] r_fail_cnt;
    logic             r_overflow;
    logic [ADDR-1:0]  r_last_addr;
    logic             r_last_vld;

    logic             w_mismatch;
    logic             w_dup;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_log_valid;
    logic [ADDR:0]    w_head;
    logic [LCW-1:0]   w_count;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_enter = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus_if.mode && !bus_if.bist_done) begin
                    w_next  = CAPTURE;
                    w_enter = 1'b1;
                end
            end
            CAPTURE: begin
                if (!bus_if.mode)          w_next = IDLE;
                else if (bus_if.bist_done) w_next = DONE;
            end
            DONE: begin
                if (!bus_if.mode) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // ---------------- compare pipeline (RAM read latency 1) ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stb_d  <= 1'b0;
            r_addr_d <= '0;
            r_exp_d  <= 1'b0;
        end else begin
            r_stb_d  <= bus_if.rd_stb;
            r_addr_d <= bus_if.addr_bist;
            r_exp_d  <= bus_if.exp_data;
        end
    end

    // The compare of the last read is still live in the cycle bist_done is
    // sampled, because the state only leaves CAPTURE on that edge.
    assign w_mismatch = (r_state == CAPTURE) && bus_if.mode && r_stb_d &&
                        (bus_if.mem_d_out != r_exp_d);
    assign w_dup      = r_last_vld && (r_addr_d == r_last_addr);
    assign w_push     = w_mismatch && !w_dup && !w_full;

    // ---------------- counters / duplicate tracking ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail_cnt  <= '0;
            r_overflow  <= 1'b0;
            r_last_addr <= '0;
            r_last_vld  <= 1'b0;
        end else if (w_enter) begin
            r_fail_cnt  <= '0;
            r_overflow  <= 1'b0;
            r_last_vld  <= 1'b0;
        end else if (w_mismatch) begin
            if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + CNT_W'(1);
            // A dropped entry was never pushed, so it does not become the
            // duplicate-suppression reference.
            if (!w_dup) begin
                if (w_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_last_addr <= r_addr_d;
                    r_last_vld  <= 1'b1;
                end
            end
        end
    end

    // ---------------- entry storage ----------------
    assign w_pop = bus_if.log_pop && w_log_valid;

    mbist_log_fifo #(
        .WIDTH (ADDR + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_enter),
        .i_push  (w_push),
        .i_wdata ({r_addr_d, r_exp_d}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // ---------------- outputs ----------------
    assign w_log_valid      = (r_state == DONE) && !w_empty;
    // Head is masked so stale, unreset storage never shows on the outputs.
    assign bus_if.log_valid = w_log_valid;
    assign bus_if.log_addr  = w_log_valid ? w_head[ADDR:1] : '0;
    assign bus_if.log_exp   = w_log_valid ? w_head[0] : 1'b0;
    assign bus_if.log_cnt   = w_count;
    assign bus_if.fail_cnt  = r_fail_cnt;
    assign bus_if.overflow  = r_overflow;
    assign bus_if.diag_done = (r_state == DONE);

endmodule
`default_nettype wire
